// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix column scanner: controller state
// encoding, default timing constants and the timer load helper.
package matrix_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_ROW,
        WAIT_ROW,
        BLANK,
        SELECT,
        WAIT_COL,
        LATCH,
        DWELL
    } scan_state_t;

    localparam int DEFAULT_NUM_COLUMNS  = 8;
    localparam int DEFAULT_BLANK_CYCLES = 4;
    localparam int DEFAULT_DWELL_CYCLES = 1024;
    localparam int TIMER_WIDTH          = 16;

    // The timer reports done once it has counted down to zero, so a phase
    // lasting N clocks is loaded with N-1 on entry.
    function automatic logic [TIMER_WIDTH-1:0] timer_load(input int cycles);
        return TIMER_WIDTH'(cycles - 1);
    endfunction

endpackage

// File: rtl/matrix_scan_controller_if.sv
// Signal bundle between the scan controller and its row-data shifter and
// column selector. The controller is the master side.
interface matrix_scan_controller_if #(
    parameter int NUM_COLUMNS = 8
);

    localparam int COL_W = $clog2(NUM_COLUMNS);

    logic             enable;
    logic             frame_pending;
    logic             col_ready;
    logic             col_select_first;
    logic             col_select_next;
    logic             row_tx_start;
    logic             row_tx_finish;
    logic             row_stcp;
    logic [COL_W-1:0] column_index;
    logic             frame_swap;
    logic             busy;

    modport master (
        input  enable,
        input  frame_pending,
        input  col_ready,
        input  row_tx_finish,
        output col_select_first,
        output col_select_next,
        output row_tx_start,
        output row_stcp,
        output column_index,
        output frame_swap,
        output busy
    );

    modport slave (
        output enable,
        output frame_pending,
        output col_ready,
        output row_tx_finish,
        input  col_select_first,
        input  col_select_next,
        input  row_tx_start,
        input  row_stcp,
        input  column_index,
        input  frame_swap,
        input  busy
    );

endinterface

// File: rtl/matrix_scan_controller_scan_timer.sv
// Loadable 16-bit down-counter timing the blanking and dwell phases.
// done is high whenever the count has reached zero.
module scan_timer
    import matrix_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] load_value,
    output logic                   done
);

    logic [TIMER_WIDTH-1:0] count;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/matrix_scan_controller.sv
// Column-multiplexed LED matrix scan controller. For each column it loads
// the row data, blanks, selects the column, latches the row register and
// dwells, then moves on; at frame end it optionally requests a buffer swap.
// Every output comes straight from a flop, computed from the next state.
module matrix_scan_controller
    import matrix_pkg::*;
#(
    parameter int NUM_COLUMNS  = DEFAULT_NUM_COLUMNS,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
    parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    matrix_scan_controller_if.master bus
);

    localparam int                     COL_W      = $clog2(NUM_COLUMNS);
    localparam logic [COL_W-1:0]       LAST_COL   = COL_W'(NUM_COLUMNS - 1);
    localparam logic [TIMER_WIDTH-1:0] BLANK_LOAD = timer_load(BLANK_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] DWELL_LOAD = timer_load(DWELL_CYCLES);

    scan_state_t            state;
    scan_state_t            state_next;
    logic [COL_W-1:0]       column_index;
    logic [COL_W-1:0]       col_next;
    logic                   swap_next;
    logic                   timer_load_en;
    logic [TIMER_WIDTH-1:0] timer_load_value;
    logic                   timer_done;

    logic                   sel_first_q;
    logic                   sel_next_q;
    logic                   row_tx_start_q;
    logic                   row_stcp_q;
    logic                   frame_swap_q;
    logic                   busy_q;

    scan_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load_en),
        .load_value (timer_load_value),
        .done       (timer_done)
    );

    // Next-state, next column and frame-swap decision.
    always_comb begin
        state_next = state;
        col_next   = column_index;
        swap_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.enable && bus.col_ready) begin
                    state_next = LOAD_ROW;
                    col_next   = '0;
                end
            end
            LOAD_ROW: begin
                if (!bus.row_tx_finish) begin
                    state_next = WAIT_ROW;
                end
            end
            WAIT_ROW: begin
                if (bus.row_tx_finish) begin
                    state_next = BLANK;
                end
            end
            BLANK: begin
                if (timer_done) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                if (!bus.col_ready) begin
                    state_next = WAIT_COL;
                end
            end
            WAIT_COL: begin
                if (bus.col_ready) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                state_next = DWELL;
            end
            DWELL: begin
                if (timer_done) begin
                    if (column_index != LAST_COL) begin
                        col_next   = column_index + 1'b1;
                        state_next = LOAD_ROW;
                    end else begin
                        col_next   = '0;
                        swap_next  = bus.frame_pending;
                        state_next = bus.enable ? LOAD_ROW : IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reload the shared timer on entry to the blanking or dwell phase.
    always_comb begin
        timer_load_en    = 1'b0;
        timer_load_value = '0;
        if (state_next == BLANK && state != BLANK) begin
            timer_load_en    = 1'b1;
            timer_load_value = BLANK_LOAD;
        end else if (state_next == DWELL && state != DWELL) begin
            timer_load_en    = 1'b1;
            timer_load_value = DWELL_LOAD;
        end
    end

    // State, column and output registers; outputs track the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            column_index   <= '0;
            sel_first_q    <= 1'b0;
            sel_next_q     <= 1'b0;
            row_tx_start_q <= 1'b0;
            row_stcp_q     <= 1'b0;
            frame_swap_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state          <= state_next;
            column_index   <= col_next;
            sel_first_q    <= (state_next == SELECT) && (col_next == '0);
            sel_next_q     <= (state_next == SELECT) && (col_next != '0);
            row_tx_start_q <= (state_next == LOAD_ROW);
            row_stcp_q     <= (state_next == LATCH);
            frame_swap_q   <= swap_next;
            busy_q         <= (state_next != IDLE);
        end
    end

    assign bus.col_select_first = sel_first_q;
    assign bus.col_select_next  = sel_next_q;
    assign bus.row_tx_start     = row_tx_start_q;
    assign bus.row_stcp         = row_stcp_q;
    assign bus.column_index     = column_index;
    assign bus.frame_swap       = frame_swap_q;
    assign bus.busy             = busy_q;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed bench for matrix_scan_controller with ideal row-shifter and
// column-selector models and an event monitor recording pulses.
module tb_matrix_scan_controller;
    import matrix_pkg::*;

    localparam int NCOL       = 8;
    localparam int BLANK_CYC  = 2;
    localparam int DWELL_CYC  = 10;
    localparam int XFER_CYC   = 3;
    localparam int HSK_CYC    = 2;
    // LOAD_ROW + transfer + blank + (SELECT + handshake) + LATCH + dwell
    localparam int COL_PERIOD = 1 + XFER_CYC + BLANK_CYC + (1 + HSK_CYC) + 1 + DWELL_CYC;
    // frame_swap follows the column-7 latch pulse by LATCH->DWELL plus the dwell
    localparam int SWAP_GAP   = 1 + DWELL_CYC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    matrix_scan_controller_if #(.NUM_COLUMNS(NCOL)) bus ();

    matrix_scan_controller #(
        .NUM_COLUMNS  (NCOL),
        .BLANK_CYCLES (BLANK_CYC),
        .DWELL_CYCLES (DWELL_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Row shifter model: accepts a start by dropping finish, raises it XFER_CYC later.
    int xfer_left = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.row_tx_finish = 1'b1;
            xfer_left = 0;
        end else if (xfer_left > 0) begin
            xfer_left--;
            if (xfer_left == 0) bus.row_tx_finish = 1'b1;
        end else if (bus.row_tx_start && bus.row_tx_finish) begin
            bus.row_tx_finish = 1'b0;
            xfer_left = XFER_CYC;
        end
    end

    // Column selector model: acknowledges a select by dropping ready for HSK_CYC.
    bit stall_col = 1'b0;
    int hsk_left  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.col_ready = 1'b1;
            hsk_left = 0;
        end else if (hsk_left > 0) begin
            hsk_left--;
            if (hsk_left == 0) bus.col_ready = 1'b1;
        end else if ((bus.col_select_first || bus.col_select_next) && bus.col_ready && !stall_col) begin
            bus.col_ready = 1'b0;
            hsk_left = HSK_CYC;
        end
    end

    // Event monitor: records latch pulses, select rises, swaps and row starts.
    int   cyc = 0;
    int   stcp_cyc_q[$];
    int   stcp_col_q[$];
    bit   sel_seq[$];
    int   sel_col[$];
    int   swap_gap_q[$];
    int   swap_col_q[$];
    int   swap_idx_q[$];
    int   start_cnt = 0;
    int   both_cnt  = 0;
    int   last_stcp_cyc = 0;
    int   last_stcp_col = 0;
    logic prev_first = 1'b0;
    logic prev_next  = 1'b0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (bus.row_stcp === 1'b1) begin
            stcp_cyc_q.push_back(cyc);
            stcp_col_q.push_back(int'(bus.column_index));
            last_stcp_cyc = cyc;
            last_stcp_col = int'(bus.column_index);
        end
        if (bus.frame_swap === 1'b1) begin
            swap_gap_q.push_back(cyc - last_stcp_cyc);
            swap_col_q.push_back(last_stcp_col);
            swap_idx_q.push_back(int'(bus.column_index));
        end
        if (bus.col_select_first === 1'b1 && !prev_first) begin
            sel_seq.push_back(1'b1);
            sel_col.push_back(int'(bus.column_index));
        end
        if (bus.col_select_next === 1'b1 && !prev_next) begin
            sel_seq.push_back(1'b0);
            sel_col.push_back(int'(bus.column_index));
        end
        if (bus.col_select_first === 1'b1 && bus.col_select_next === 1'b1) both_cnt++;
        if (bus.row_tx_start === 1'b1 && !prev_start) start_cnt++;
        prev_first = (bus.col_select_first === 1'b1);
        prev_next  = (bus.col_select_next === 1'b1);
        prev_start = (bus.row_tx_start === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] strobes;
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.frame_pending = 1'b0;
        repeat (3) tick();
        strobes = {bus.busy, bus.col_select_first, bus.col_select_next,
                   bus.row_tx_start, bus.row_stcp, bus.frame_swap};
        checks++;
        if (strobes !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 000000", strobes);
        end
        checks++;
        if (bus.column_index !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_column: got %0d expected 0", bus.column_index);
        end
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.row_tx_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_without_enable: got busy=%b start=%b expected 0 0",
                     bus.busy, bus.row_tx_start);
        end
    endtask

    task automatic test_select_sequence();
        int base;
        int sbase;
        int swbase;
        int both_base;
        int waited;
        bit exp_first;
        int exp_col;
        int gap;
        base      = sel_seq.size();
        sbase     = stcp_cyc_q.size();
        swbase    = swap_gap_q.size();
        both_base = both_cnt;
        bus.enable = 1'b1;
        waited = 0;
        while (stcp_cyc_q.size() < sbase + 9 && waited < 1000) begin
            tick();
            waited++;
        end
        checks++;
        if (stcp_cyc_q.size() < sbase + 9) begin
            errors++;
            $display("[TB] FAIL seq_timeout: got %0d latches expected 9", stcp_cyc_q.size() - sbase);
            return;
        end
        for (int i = 0; i < 9; i++) begin
            exp_first = (i % NCOL == 0);
            exp_col   = i % NCOL;
            checks++;
            if (sel_seq[base + i] !== exp_first || sel_col[base + i] != exp_col) begin
                errors++;
                $display("[TB] FAIL select_%0d: got first=%b col=%0d expected first=%b col=%0d",
                         i, sel_seq[base + i], sel_col[base + i], exp_first, exp_col);
            end
        end
        for (int i = 1; i < 9; i++) begin
            gap = stcp_cyc_q[sbase + i] - stcp_cyc_q[sbase + i - 1];
            checks++;
            if (gap != COL_PERIOD) begin
                errors++;
                $display("[TB] FAIL column_period_%0d: got %0d expected %0d", i, gap, COL_PERIOD);
            end
        end
        checks++;
        if (both_cnt != both_base) begin
            errors++;
            $display("[TB] FAIL select_exclusive: got %0d overlaps expected 0", both_cnt - both_base);
        end
        checks++;
        if (swap_gap_q.size() != swbase) begin
            errors++;
            $display("[TB] FAIL no_swap_without_pending: got %0d swaps expected 0",
                     swap_gap_q.size() - swbase);
        end
    endtask

    task automatic test_frame_swap();
        int waited;
        int sbase;
        int swbase;
        bus.frame_pending = 1'b1;
        waited = 0;
        while (!(bus.row_stcp === 1'b1 && bus.column_index == 3'd0) && waited < 400) begin
            tick();
            waited++;
        end
        sbase  = stcp_cyc_q.size();
        swbase = swap_gap_q.size();
        waited = 0;
        while (stcp_cyc_q.size() < sbase + 16 && waited < 1000) begin
            tick();
            waited++;
        end
        checks++;
        if (stcp_cyc_q.size() < sbase + 16) begin
            errors++;
            $display("[TB] FAIL swap_timeout: got %0d latches expected 16", stcp_cyc_q.size() - sbase);
            bus.frame_pending = 1'b0;
            return;
        end
        checks++;
        if (swap_gap_q.size() - swbase != 2) begin
            errors++;
            $display("[TB] FAIL swap_count: got %0d expected 2", swap_gap_q.size() - swbase);
        end
        for (int i = swbase; i < swap_gap_q.size(); i++) begin
            checks++;
            if (swap_gap_q[i] != SWAP_GAP || swap_col_q[i] != NCOL - 1 || swap_idx_q[i] != 0) begin
                errors++;
                $display("[TB] FAIL swap_timing: got gap=%0d lastcol=%0d idx=%0d expected gap=%0d lastcol=%0d idx=0",
                         swap_gap_q[i], swap_col_q[i], swap_idx_q[i], SWAP_GAP, NCOL - 1);
            end
        end
        bus.frame_pending = 1'b0;
    endtask

    task automatic test_enable_drop();
        int waited;
        int sbase;
        int stbase;
        waited = 0;
        while (!(bus.row_stcp === 1'b1 && bus.column_index == 3'd3) && waited < 400) begin
            tick();
            waited++;
        end
        bus.enable = 1'b0;
        sbase  = stcp_cyc_q.size();
        stbase = start_cnt;
        waited = 0;
        while (bus.busy !== 1'b0 && waited < 400) begin
            tick();
            waited++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_idle_timeout: got busy=%b expected 0", bus.busy);
            return;
        end
        checks++;
        if (stcp_cyc_q.size() - sbase != 4) begin
            errors++;
            $display("[TB] FAIL drop_latch_count: got %0d expected 4", stcp_cyc_q.size() - sbase);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (stcp_col_q[sbase + i] != 4 + i) begin
                    errors++;
                    $display("[TB] FAIL drop_column_%0d: got %0d expected %0d",
                             i, stcp_col_q[sbase + i], 4 + i);
                end
            end
        end
        repeat (50) tick();
        checks++;
        if (start_cnt - stbase != 4 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_no_restart: got starts=%0d busy=%b expected starts=4 busy=0",
                     start_cnt - stbase, bus.busy);
        end
    endtask

    task automatic test_col_stall();
        int waited;
        int sbase;
        int bad;
        stall_col  = 1'b1;
        sbase      = stcp_cyc_q.size();
        bus.enable = 1'b1;
        waited = 0;
        while (bus.col_select_first !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        if (bus.col_select_first !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_select_timeout: got %b expected 1", bus.col_select_first);
            stall_col = 1'b0;
            return;
        end
        bad = 0;
        repeat (50) begin
            tick();
            if (bus.col_select_first !== 1'b1 || bus.col_select_next !== 1'b0 ||
                stcp_cyc_q.size() != sbase) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL stall_hold: got %0d bad cycles expected 0", bad);
        end
        stall_col = 1'b0;
        waited = 0;
        while (stcp_cyc_q.size() == sbase && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (stcp_cyc_q.size() == sbase) begin
            errors++;
            $display("[TB] FAIL stall_release: got no latch expected one");
        end else if (stcp_col_q[sbase] != 0) begin
            errors++;
            $display("[TB] FAIL stall_release: got column %0d expected 0", stcp_col_q[sbase]);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        int base;
        logic [5:0] strobes;
        waited = 0;
        while (!(bus.row_stcp === 1'b1 && bus.column_index == 3'd2) && waited < 400) begin
            tick();
            waited++;
        end
        waited = 0;
        while (bus.row_tx_start !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        while (bus.row_tx_start !== 1'b0 && waited < 200) begin
            tick();
            waited++;
        end
        checks++;
        if (bus.column_index !== 3'd3 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL premid_state: got col=%0d busy=%b expected col=3 busy=1",
                     bus.column_index, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        strobes = {bus.busy, bus.col_select_first, bus.col_select_next,
                   bus.row_tx_start, bus.row_stcp, bus.frame_swap};
        checks++;
        if (strobes !== 6'b0 || bus.column_index !== 3'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b col=%0d expected 000000 col=0",
                     strobes, bus.column_index);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        base = sel_seq.size();
        waited = 0;
        while (sel_seq.size() == base && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        if (sel_seq.size() == base) begin
            errors++;
            $display("[TB] FAIL restart_timeout: got no select expected col_select_first");
        end else if (sel_seq[base] !== 1'b1 || sel_col[base] != 0) begin
            errors++;
            $display("[TB] FAIL restart_select: got first=%b col=%0d expected first=1 col=0",
                     sel_seq[base], sel_col[base]);
        end
    endtask

    initial begin
        bus.enable        = 1'b0;
        bus.frame_pending = 1'b0;
        test_reset();
        test_select_sequence();
        test_frame_swap();
        test_enable_drop();
        test_col_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_scan_controller.md
MATRIX_SCAN_CONTROLLER -- requirements
Module: matrix_scan_controller

Interface
REQ-001 Parameter NUM_COLUMNS, default 8: columns scanned per frame; legal range 2..256.
REQ-002 Parameter BLANK_CYCLES, default 4: clocks the row latch is held off before a column change; legal range 1..65535.
REQ-003 Parameter DWELL_CYCLES, default 1024: clocks a column stays lit after its row latch; legal range 1..65535.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 enable  in  1  scan run request.
REQ-007 frame_pending  in  1  new frame buffer ready for display.
REQ-008 col_ready  in  1  column selector can accept a select.
REQ-009 col_select_first  out  1  select column 0.
REQ-010 col_select_next  out  1  advance to the next column.
REQ-011 row_tx_start  out  1  start row-data SPI transfer.
REQ-012 row_tx_finish  in  1  row transfer complete, level.
REQ-013 row_stcp  out  1  row storage-register latch, one-cycle pulse.
REQ-014 column_index  out  $clog2(NUM_COLUMNS)  column whose row data is being loaded/shown.
REQ-015 frame_swap  out  1  one-cycle pulse; consumer swaps buffers.
REQ-016 busy  out  1  high in any state except IDLE.

Function
REQ-017 States: IDLE, LOAD_ROW, WAIT_ROW, BLANK, SELECT, WAIT_COL, LATCH, DWELL.
REQ-018 IDLE -> LOAD_ROW when enable=1 and col_ready=1; column_index <= 0 on that transition.
REQ-019 LOAD_ROW: row_tx_start=1; stay until row_tx_finish=0 (transfer accepted), then -> WAIT_ROW.
REQ-020 WAIT_ROW: row_tx_start=0; -> BLANK when row_tx_finish=1.
REQ-021 BLANK: count BLANK_CYCLES clocks, then -> SELECT.
REQ-022 SELECT: assert col_select_first if column_index=0, otherwise col_select_next; hold until col_ready=0, then deassert and -> WAIT_COL.
REQ-023 Never assert col_select_first and col_select_next in the same cycle.
REQ-024 WAIT_COL: -> LATCH when col_ready=1.
REQ-025 LATCH: row_stcp=1 for exactly one cycle, then -> DWELL.
REQ-026 DWELL: count DWELL_CYCLES clocks. At expiry:
- if column_index < NUM_COLUMNS-1: increment column_index, -> LOAD_ROW.
- else (frame end): wrap column_index to 0; if frame_pending=1, pulse frame_swap in that cycle.
- then -> LOAD_ROW if enable=1, otherwise -> IDLE.
REQ-027 enable=0 mid-frame: the current column completes through DWELL; the controller enters IDLE only at frame end.
REQ-028 frame_pending is sampled only at frame end; at most one frame_swap per frame.
REQ-029 All outputs are registered; no combinational path from any input to any output.
REQ-030 Counters are 16 bits and saturate-free; reload on state entry.

Reset
REQ-031 rst_n=0 forces, asynchronously: state IDLE, column_index 0, counters 0, all strobes/selects 0, busy 0.
REQ-032 A reset asserted mid-operation aborts immediately; after release, scanning restarts from column 0 via IDLE.

Structure
REQ-033 The state enum and default timing constants live in the shared package matrix_pkg.
REQ-034 One sub-module, scan_timer: loadable 16-bit down-counter with a done flag, used by BLANK and DWELL.

Verification
REQ-035 NUM_COLUMNS=8, BLANK=2, DWELL=10, enable=1, ideal models: first select is col_select_first, next 7 are col_select_next; then col_select_first repeats. Column period = 1+transfer+2+handshake+1+10 cycles.
REQ-036 frame_pending=1 held: exactly one frame_swap per 8 row_stcp pulses, coincident with DWELL expiry of column 7.
REQ-037 enable dropped during column 3: columns 4-7 still scanned, then busy=0, no further row_tx_start.
REQ-038 col_ready held low 50 cycles in SELECT: select stays high; no row_stcp until col_ready falls, then rises.
REQ-039 rst_n pulsed low during WAIT_ROW: all outputs 0 in the same cycle; after release, next select is col_select_first with column_index=0.
